// File: rtl/mmio_if.sv
// Load/store bus between the core's data-memory mux and the MMIO responder.
// The master drives requests; the slave returns registered load data.
interface mmio_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output rd_en, output wr_en, output wdata, input rdata);
  modport slave  (input addr, input rd_en, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder for the Riscv151 core: UART status/data, cycle and instruction
// counters, a button-event FIFO, switches and LEDs behind a one-cycle load path.
module mmio_responder #(
  parameter int BTN_FIFO_DEPTH = 8,
  parameter int LED_WIDTH      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_if.slave                mmio,
  input  logic                 inst_retire,
  input  logic [7:0]           uart_rx_data,
  input  logic                 uart_rx_valid,
  output logic                 uart_rx_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready,
  input  logic [2:0]           clean_buttons,
  input  logic [1:0]           switches,
  output logic [LED_WIDTH-1:0] leds
);
  localparam int PTR_W = $clog2(BTN_FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL_COUNT = (PTR_W + 1)'(BTN_FIFO_DEPTH);

  localparam logic [7:0] OFF_UART_CTRL = 8'h00;
  localparam logic [7:0] OFF_UART_RX   = 8'h04;
  localparam logic [7:0] OFF_UART_TX   = 8'h08;
  localparam logic [7:0] OFF_CYCLE     = 8'h10;
  localparam logic [7:0] OFF_INSTR     = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR   = 8'h18;
  localparam logic [7:0] OFF_FIFO_STAT = 8'h20;
  localparam logic [7:0] OFF_FIFO_DATA = 8'h24;
  localparam logic [7:0] OFF_SWITCHES  = 8'h28;
  localparam logic [7:0] OFF_LEDS      = 8'h30;

  logic [7:0]           offset;
  logic [31:0]          rdata_reg;
  logic [31:0]          rdata_next;
  logic [31:0]          cycle_cnt_reg;
  logic [31:0]          instr_cnt_reg;
  logic [7:0]           tx_data_reg;
  logic                 tx_valid_reg;
  logic [LED_WIDTH-1:0] leds_reg;
  logic [2:0]           btn_prev_reg;
  logic [2:0]           btn_rise;
  logic [2:0]           fifo_mem [BTN_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W:0]       count_reg;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic                 tx_accept;
  logic                 cnt_clear;
  logic                 led_write;
  logic                 unused_ok;

  assign offset     = mmio.addr[7:0];
  assign unused_ok  = ^{mmio.addr[31:8], mmio.wdata};

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FIFO_FULL_COUNT);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn_edge
      assign btn_rise[gi] = clean_buttons[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being read; an empty FIFO never pops, even if a push arrives.
  assign fifo_pop  = mmio.rd_en && (offset == OFF_FIFO_DATA) && !fifo_empty;
  assign fifo_push = (|btn_rise) && (!fifo_full || fifo_pop);

  assign tx_accept = mmio.wr_en && (offset == OFF_UART_TX) && uart_tx_ready;
  assign cnt_clear = mmio.wr_en && (offset == OFF_CNT_CLR);
  assign led_write = mmio.wr_en && (offset == OFF_LEDS);

  // The receiver pop is combinational so it lands in the same cycle as the load.
  assign uart_rx_ready = mmio.rd_en && (offset == OFF_UART_RX) && !rst;

  always_comb begin
    rdata_next = '0;
    case (offset)
      OFF_UART_CTRL: rdata_next = {30'b0, uart_rx_valid, uart_tx_ready};
      OFF_UART_RX:   rdata_next = {24'b0, uart_rx_data};
      OFF_CYCLE:     rdata_next = cycle_cnt_reg;
      OFF_INSTR:     rdata_next = instr_cnt_reg;
      OFF_FIFO_STAT: rdata_next = {31'b0, fifo_empty};
      OFF_FIFO_DATA: rdata_next = fifo_empty ? 32'b0 : {29'b0, fifo_mem[rd_ptr_reg]};
      OFF_SWITCHES:  rdata_next = {30'b0, switches};
      default:       rdata_next = '0;
    endcase
  end

  // Storage carries no reset so it can map onto RAM; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= clean_buttons;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg     <= '0;
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      leds_reg      <= '0;
      btn_prev_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      if (mmio.rd_en) begin
        rdata_reg <= rdata_next;
      end
      tx_valid_reg <= tx_accept;
      if (tx_accept) begin
        tx_data_reg <= mmio.wdata[7:0];
      end
      if (led_write) begin
        leds_reg <= mmio.wdata[LED_WIDTH-1:0];
      end
      if (cnt_clear) begin
        cycle_cnt_reg <= '0;
        instr_cnt_reg <= '0;
      end else begin
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        if (inst_retire) begin
          instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
      end
      btn_prev_reg <= clean_buttons;
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign mmio.rdata    = rdata_reg;
  assign uart_tx_data  = tx_data_reg;
  assign uart_tx_valid = tx_valid_reg;
  assign leds          = leds_reg;
endmodule
